// File: rtl/bpu_pkg.sv
// Shared branch-prediction package.
// Holds the default widths used by the predictor blocks and the width of one
// in-flight branch record {idx, taken, fallthru} as stored by the tracker.
package bpu_pkg;

  localparam int unsigned BPU_DEPTH = 4;   // max in-flight predicted branches
  localparam int unsigned BPU_IDX_W = 5;   // predictor table index width
  localparam int unsigned BPU_PC_W  = 32;  // program counter width

  // Entry record layout, MSB to LSB: idx | taken | fallthru
  localparam int unsigned BPU_ENTRY_W = BPU_IDX_W + 1 + BPU_PC_W;

  localparam int unsigned BPU_CNT_W   = 16;
  localparam logic [15:0] BPU_CNT_MAX = 16'hFFFF;

  // Record width for non-default index/PC widths.
  function automatic int unsigned bpu_entry_w(input int unsigned idx_w,
                                              input int unsigned pc_w);
    return idx_w + 1 + pc_w;
  endfunction

endpackage

// File: rtl/bot_fifo.sv
// In-order FIFO holding the outstanding predicted branches.
// Ports:
//   clk, arst_n   clock, asynchronous active-low reset (pointers/occupancy only)
//   push, din     write din at the tail
//   pop           drop the head entry
//   clear         discard every entry; takes priority over push/pop
//   full, empty   occupancy == DEPTH / occupancy == 0
//   head          current head entry (valid while !empty)
// Push and pop together leave occupancy unchanged, including when full: the
// tail slot then equals the head slot, which is read combinationally before
// the edge that overwrites it.
module bot_fifo
  import bpu_pkg::*;
#(
  parameter int unsigned DEPTH = BPU_DEPTH,
  parameter int unsigned W     = BPU_ENTRY_W
) (
  input  logic         clk,
  input  logic         arst_n,
  input  logic         push,
  input  logic         pop,
  input  logic         clear,
  input  logic [W-1:0] din,
  output logic         full,
  output logic         empty,
  output logic [W-1:0] head
);

  localparam int unsigned PW = $clog2(DEPTH);

  logic [PW-1:0] wptr_q, wptr_d;
  logic [PW-1:0] rptr_q, rptr_d;
  logic [PW:0]   cnt_q,  cnt_d;
  logic [W-1:0]  mem_q [DEPTH];

  // Pointers wrap naturally because DEPTH is a power of two.
  always_comb begin
    wptr_d = wptr_q;
    rptr_d = rptr_q;
    cnt_d  = cnt_q;
    if (clear) begin
      wptr_d = '0;
      rptr_d = '0;
      cnt_d  = '0;
    end else begin
      if (push) wptr_d = wptr_q + PW'(1);
      if (pop)  rptr_d = rptr_q + PW'(1);
      case ({push, pop})
        2'b10:   cnt_d = cnt_q + (PW+1)'(1);
        2'b01:   cnt_d = cnt_q - (PW+1)'(1);
        default: cnt_d = cnt_q;
      endcase
    end
  end

  always_ff @(posedge clk or negedge arst_n) begin
    if (!arst_n) begin
      wptr_q <= '0;
      rptr_q <= '0;
      cnt_q  <= '0;
    end else begin
      wptr_q <= wptr_d;
      rptr_q <= rptr_d;
      cnt_q  <= cnt_d;
    end
  end

  // Payload storage carries no reset; occupancy alone says what is valid.
  always_ff @(posedge clk) begin
    if (push && !clear) mem_q[wptr_q] <= din;
  end

  assign full  = (cnt_q == (PW+1)'(DEPTH));
  assign empty = (cnt_q == '0);
  assign head  = mem_q[rptr_q];

endmodule

// File: rtl/branch_outcome_tracker.sv
// Branch outcome tracker: remembers each predicted branch in fetch order and,
// when EX resolves the oldest one, compares prediction against outcome.
// Ports:
//   pred_valid/idx/taken/fallthru, pred_ready   record a predicted branch
//   res_valid/taken/target                      resolve the oldest branch
//   flush, redirect_pc                          one-cycle mispredict redirect
//   upd_en/addr/taken                           predictor training strobe
//   branch_cnt, mispred_cnt                     saturating statistics
//   err_underflow                               sticky: resolve while empty
// All outputs are registered: one cycle from resolve to flush/update.
module branch_outcome_tracker
  import bpu_pkg::*;
#(
  parameter int unsigned DEPTH = BPU_DEPTH,
  parameter int unsigned IDX_W = BPU_IDX_W,
  parameter int unsigned PC_W  = BPU_PC_W
) (
  input  logic             clk,
  input  logic             arst_n,
  input  logic             pred_valid,
  input  logic [IDX_W-1:0] pred_idx,
  input  logic             pred_taken,
  input  logic [PC_W-1:0]  pred_fallthru,
  output logic             pred_ready,
  input  logic             res_valid,
  input  logic             res_taken,
  input  logic [PC_W-1:0]  res_target,
  output logic             flush,
  output logic [PC_W-1:0]  redirect_pc,
  output logic             upd_en,
  output logic [IDX_W-1:0] upd_addr,
  output logic             upd_taken,
  output logic [15:0]      branch_cnt,
  output logic [15:0]      mispred_cnt,
  output logic             err_underflow
);

  localparam int unsigned EW = bpu_entry_w(IDX_W, PC_W);

  function automatic logic [15:0] sat_inc(input logic [15:0] v);
    return (v == BPU_CNT_MAX) ? v : v + 16'd1;
  endfunction

  logic          fifo_full, fifo_empty;
  logic [EW-1:0] head, din;
  logic          pop, push, mispred;

  logic [IDX_W-1:0] head_idx;
  logic             head_taken;
  logic [PC_W-1:0]  head_fallthru;

  logic             flush_q,   flush_d;
  logic [PC_W-1:0]  redir_q,   redir_d;
  logic             upd_en_q,  upd_en_d;
  logic [IDX_W-1:0] upd_addr_q, upd_addr_d;
  logic             upd_tk_q,  upd_tk_d;
  logic [15:0]      bcnt_q,    bcnt_d;
  logic [15:0]      mcnt_q,    mcnt_d;
  logic             err_q,     err_d;

  assign head_idx      = head[EW-1 -: IDX_W];
  assign head_taken    = head[PC_W];
  assign head_fallthru = head[PC_W-1:0];
  assign din           = {pred_idx, pred_taken, pred_fallthru};

  assign pop     = res_valid && !fifo_empty;
  assign mispred = pop && (head_taken != res_taken);
  // A full tracker still takes a new branch when the head retires in the
  // same cycle; a mispredict discards everything, the incoming entry too.
  assign push    = pred_valid && (!fifo_full || pop) && !mispred;

  bot_fifo #(.DEPTH(DEPTH), .W(EW)) u_fifo (
    .clk    (clk),
    .arst_n (arst_n),
    .push   (push),
    .pop    (pop),
    .clear  (mispred),
    .din    (din),
    .full   (fifo_full),
    .empty  (fifo_empty),
    .head   (head)
  );

  always_comb begin
    flush_d    = mispred;
    upd_en_d   = pop;
    redir_d    = redir_q;
    upd_addr_d = upd_addr_q;
    upd_tk_d   = upd_tk_q;
    bcnt_d     = bcnt_q;
    mcnt_d     = mcnt_q;
    err_d      = err_q | (res_valid && fifo_empty);
    if (pop) begin
      upd_addr_d = head_idx;
      upd_tk_d   = res_taken;
      bcnt_d     = sat_inc(bcnt_q);
    end
    if (mispred) begin
      redir_d = res_taken ? res_target : head_fallthru;
      mcnt_d  = sat_inc(mcnt_q);
    end
  end

  always_ff @(posedge clk or negedge arst_n) begin
    if (!arst_n) begin
      flush_q    <= 1'b0;
      redir_q    <= '0;
      upd_en_q   <= 1'b0;
      upd_addr_q <= '0;
      upd_tk_q   <= 1'b0;
      bcnt_q     <= '0;
      mcnt_q     <= '0;
      err_q      <= 1'b0;
    end else begin
      flush_q    <= flush_d;
      redir_q    <= redir_d;
      upd_en_q   <= upd_en_d;
      upd_addr_q <= upd_addr_d;
      upd_tk_q   <= upd_tk_d;
      bcnt_q     <= bcnt_d;
      mcnt_q     <= mcnt_d;
      err_q      <= err_d;
    end
  end

  assign pred_ready    = !fifo_full;
  assign flush         = flush_q;
  assign redirect_pc   = redir_q;
  assign upd_en        = upd_en_q;
  assign upd_addr      = upd_addr_q;
  assign upd_taken     = upd_tk_q;
  assign branch_cnt    = bcnt_q;
  assign mispred_cnt   = mcnt_q;
  assign err_underflow = err_q;

endmodule

// File: tb/tb_branch_outcome_tracker.sv
module tb_branch_outcome_tracker;

  localparam int DEPTH = 4;

  logic        clk = 1'b0;
  logic        arst_n;
  logic        pred_valid;
  logic [4:0]  pred_idx;
  logic        pred_taken;
  logic [31:0] pred_fallthru;
  logic        pred_ready;
  logic        res_valid;
  logic        res_taken;
  logic [31:0] res_target;
  logic        flush;
  logic [31:0] redirect_pc;
  logic        upd_en;
  logic [4:0]  upd_addr;
  logic        upd_taken;
  logic [15:0] branch_cnt;
  logic [15:0] mispred_cnt;
  logic        err_underflow;

  branch_outcome_tracker dut (
    .clk(clk), .arst_n(arst_n),
    .pred_valid(pred_valid), .pred_idx(pred_idx), .pred_taken(pred_taken),
    .pred_fallthru(pred_fallthru), .pred_ready(pred_ready),
    .res_valid(res_valid), .res_taken(res_taken), .res_target(res_target),
    .flush(flush), .redirect_pc(redirect_pc),
    .upd_en(upd_en), .upd_addr(upd_addr), .upd_taken(upd_taken),
    .branch_cnt(branch_cnt), .mispred_cnt(mispred_cnt),
    .err_underflow(err_underflow)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [4:0]  idx;
    logic        taken;
    logic [31:0] fall;
  } ent_t;

  typedef struct {
    logic [4:0]  addr;
    logic        taken;
    logic        flush;
    logic [31:0] redir;
    logic [15:0] bc;
    logic [15:0] mc;
  } exp_t;

  // Reference model state: outstanding branches in program order.
  ent_t m_q[$];
  exp_t exp_q[$];
  int   m_bc, m_mc;
  bit   m_err;

  int total = 0;
  int bad   = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, req);
    end
  endtask

  // One cycle: check ready/error state, drive inputs, advance the model,
  // queue the expected update (if any), then move to 1ns after the edge.
  task automatic step(input logic pv, input logic [4:0] pi, input logic pt,
                      input logic [31:0] pf, input logic rv, input logic rt,
                      input logic [31:0] rtg);
    int   size0;
    bit   popped, mis;
    ent_t h;
    exp_t e;
    size0 = m_q.size();
    chk("pred_ready", pred_ready, (size0 < DEPTH) ? 1 : 0);
    chk("err_underflow", err_underflow, m_err);
    pred_valid = pv; pred_idx = pi; pred_taken = pt; pred_fallthru = pf;
    res_valid = rv; res_taken = rt; res_target = rtg;
    popped = 0; mis = 0;
    if (rv && size0 == 0) m_err = 1;
    if (rv && size0 > 0) begin
      popped = 1;
      h = m_q.pop_front();
      mis = (h.taken != rt);
      if (m_bc < 65535) m_bc++;
      if (mis && m_mc < 65535) m_mc++;
      e.addr = h.idx; e.taken = rt; e.flush = mis;
      e.redir = rt ? rtg : h.fall;
      e.bc = 16'(m_bc); e.mc = 16'(m_mc);
      exp_q.push_back(e);
      if (mis) m_q.delete();
    end
    if (pv && !mis && (size0 < DEPTH || popped)) begin
      h.idx = pi; h.taken = pt; h.fall = pf;
      m_q.push_back(h);
    end
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    step(0, 0, 0, 0, 0, 0, 0);
  endtask

  // Resolve the oldest model entry with its predicted direction.
  task automatic resolve_ok(input logic pv, input logic [4:0] pi, input logic pt);
    logic t;
    t = (m_q.size() > 0) ? m_q[0].taken : 1'b0;
    step(pv, pi, pt, {25'd0, pi, 2'b00}, 1, t, 32'h1000);
  endtask

  task automatic check_all_zero(input string tag);
    chk({tag, "_flush"},  flush, 0);
    chk({tag, "_redir"},  redirect_pc, 0);
    chk({tag, "_upd_en"}, upd_en, 0);
    chk({tag, "_upd_addr"}, upd_addr, 0);
    chk({tag, "_upd_taken"}, upd_taken, 0);
    chk({tag, "_bcnt"},   branch_cnt, 0);
    chk({tag, "_mcnt"},   mispred_cnt, 0);
    chk({tag, "_err"},    err_underflow, 0);
    chk({tag, "_ready"},  pred_ready, 1);
  endtask

  task automatic do_reset();
    arst_n = 1'b0;
    m_q.delete(); exp_q.delete();
    m_bc = 0; m_mc = 0; m_err = 0;
    pred_valid = 0; res_valid = 0;
    #1;
    check_all_zero("rst_async");
    @(negedge clk);
    #2 arst_n = 1'b1;
    @(posedge clk);
    #1;
    check_all_zero("rst_after");
  endtask

  // Monitor: every upd_en pulse is matched against the oldest expectation;
  // between pulses the held outputs must keep their last values.
  logic [4:0]  last_addr;
  logic        last_taken;
  logic [31:0] last_redir;

  always @(negedge clk) begin
    if (!arst_n) begin
      last_addr = 0; last_taken = 0; last_redir = 0;
    end else if (upd_en) begin
      if (exp_q.size() == 0) begin
        chk("upd_unexpected", upd_en, 0);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        chk("upd_addr", upd_addr, e.addr);
        chk("upd_taken", upd_taken, e.taken);
        chk("flush", flush, e.flush);
        chk("branch_cnt", branch_cnt, e.bc);
        chk("mispred_cnt", mispred_cnt, e.mc);
        if (e.flush) begin
          chk("redirect_pc", redirect_pc, e.redir);
          last_redir = e.redir;
        end else begin
          chk("redirect_hold", redirect_pc, last_redir);
        end
        last_addr = e.addr; last_taken = e.taken;
      end
    end else begin
      chk("flush_idle", flush, 0);
      chk("upd_addr_hold", upd_addr, last_addr);
      chk("upd_taken_hold", upd_taken, last_taken);
      chk("redirect_idle_hold", redirect_pc, last_redir);
    end
  end

  initial begin
    arst_n = 1'b0;
    pred_valid = 0; pred_idx = 0; pred_taken = 0; pred_fallthru = 0;
    res_valid = 0; res_taken = 0; res_target = 0;
    m_bc = 0; m_mc = 0; m_err = 0;
    #3;
    check_all_zero("rst_init");
    #19 arst_n = 1'b1;
    @(posedge clk);
    #1;
    check_all_zero("rst_release");

    // Correct taken prediction trains idx 3.
    step(1, 5'd3, 1, 32'h104, 0, 0, 0);
    step(0, 0, 0, 0, 1, 1, 32'h200);
    chk("d1_upd_en", upd_en, 1);
    chk("d1_upd_addr", upd_addr, 3);
    chk("d1_flush", flush, 0);
    chk("d1_bcnt", branch_cnt, 1);

    // Not-taken predicted, taken resolved: redirect to target.
    step(1, 5'd7, 0, 32'h100, 0, 0, 0);
    step(0, 0, 0, 0, 1, 1, 32'h240);
    chk("d2_flush", flush, 1);
    chk("d2_redir", redirect_pc, 32'h240);
    chk("d2_mcnt", mispred_cnt, 1);
    idle();
    chk("d2_flush_oneshot", flush, 0);

    // Fill, then push + correct resolve while full.
    step(1, 5'd10, 1, 32'h10, 0, 0, 0);
    step(1, 5'd11, 0, 32'h14, 0, 0, 0);
    step(1, 5'd12, 1, 32'h18, 0, 0, 0);
    step(1, 5'd13, 0, 32'h1c, 0, 0, 0);
    chk("d3_full_ready", pred_ready, 0);
    step(1, 5'd14, 1, 32'h20, 1, 1, 32'h300);
    chk("d3_still_full", pred_ready, 0);
    for (int i = 0; i < 4; i++) resolve_ok(0, 0, 0);
    idle();

    // Mispredict on head with a younger fetch arriving: fallthru redirect.
    step(1, 5'd1, 1, 32'h44, 0, 0, 0);
    step(1, 5'd2, 0, 32'h48, 0, 0, 0);
    step(1, 5'd4, 1, 32'h4c, 0, 0, 0);
    step(1, 5'd20, 1, 32'h50, 1, 0, 32'h999);
    chk("d4_flush", flush, 1);
    chk("d4_redir", redirect_pc, 32'h44);
    chk("d4_ready", pred_ready, 1);

    // Resolve with nothing outstanding (the dropped fetch must not be there).
    step(0, 0, 0, 0, 1, 1, 32'h0);
    chk("d5_err", err_underflow, 1);
    chk("d5_upd_en", upd_en, 0);
    chk("d5_bcnt", branch_cnt, 16'(m_bc));
    idle(); idle();
    chk("d5_err_sticky", err_underflow, 1);

    // Randomised traffic.
    for (int i = 0; i < 3000; i++) begin
      logic pv, rv, rt, pt;
      logic [4:0] pi;
      pv = ($urandom_range(0, 9) < 6);
      rv = ($urandom_range(0, 9) < 4);
      pt = 1'($urandom);
      pi = 5'($urandom);
      if (m_q.size() > 0)
        rt = ($urandom_range(0, 3) != 0) ? m_q[0].taken : ~m_q[0].taken;
      else
        rt = 1'($urandom);
      step(pv, pi, pt, $urandom, rv, rt, $urandom);
    end
    idle(); idle();

    // Saturate branch_cnt with a stream of correct resolves.
    do_reset();
    step(1, 5'd5, 1, 32'h8, 0, 0, 0);
    for (int i = 0; i < 65537; i++) step(1, 5'(i), 1, 32'h8, 1, 1, 32'h40);
    chk("sat_bcnt", branch_cnt, 16'hFFFF);
    chk("sat_mcnt", mispred_cnt, 0);

    // Reset while an update pulse is on the outputs.
    do_reset();
    step(1, 5'd9, 0, 32'h60, 0, 0, 0);
    step(0, 0, 0, 0, 1, 1, 32'h80);
    chk("mid_pulse_present", upd_en, 1);
    do_reset();
    idle(); idle();
    chk("exp_drained", exp_q.size(), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
